// File: rtl/lfsr_gen.sv
// Configurable LFSR generator with Fibonacci/Galois stepping, period measurement
// against the start (anchor) state, and recovery from the all-zero lock-up state.
module lfsr_gen #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] FIB_TAPS = 8'hB8,
  parameter logic [WIDTH-1:0] GAL_TAPS = 8'h71,
  parameter logic [WIDTH-1:0] SEED     = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             mode_in,
  output logic [WIDTH-1:0] q,
  output logic             bit_out,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             period_vld,
  output logic             lockup
);

  typedef enum logic {
    MODE_FIB = 1'b0,
    MODE_GAL = 1'b1
  } mode_e;

  mode_e            mode;
  logic [WIDTH-1:0] anchor;
  logic [WIDTH-1:0] cnt;

  logic [WIDTH-1:0] fib_next;
  logic [WIDTH-1:0] gal_next;
  logic [WIDTH-1:0] step_next;
  logic [WIDTH-1:0] cnt_inc;

  assign fib_next  = {q[WIDTH-2:0], ^(q & FIB_TAPS)};
  assign gal_next  = {q[WIDTH-2:0], 1'b0} ^ (q[WIDTH-1] ? GAL_TAPS : '0);
  assign step_next = (mode == MODE_GAL) ? gal_next : fib_next;
  // Saturating increment shared by the step counter and the period capture.
  assign cnt_inc   = (cnt == '1) ? cnt : cnt + 1'b1;
  assign bit_out   = q[WIDTH-1];

  // NOTE: all state uses non-blocking assignments so every flop samples the
  // pre-edge values of q, anchor and cnt regardless of statement order.
  always_ff @(posedge clk) begin
    wrap   <= 1'b0;
    lockup <= 1'b0;
    if (rst) begin
      q          <= SEED;
      anchor     <= SEED;
      mode       <= MODE_FIB;
      cnt        <= '0;
      period     <= '0;
      period_vld <= 1'b0;
    end else if (load) begin
      mode       <= mode_e'(mode_in);
      cnt        <= '0;
      period_vld <= 1'b0;
      if (seed_in == '0) begin
        q      <= SEED;
        anchor <= SEED;
        lockup <= 1'b1;
      end else begin
        q      <= seed_in;
        anchor <= seed_in;
      end
    end else if (en) begin
      if (step_next == '0) begin
        // Lock-up recovery restarts the measurement but keeps the last period.
        q      <= SEED;
        anchor <= SEED;
        cnt    <= '0;
        lockup <= 1'b1;
      end else if (step_next == anchor) begin
        q          <= step_next;
        wrap       <= 1'b1;
        period     <= cnt_inc;
        period_vld <= 1'b1;
        cnt        <= '0;
      end else begin
        q   <= step_next;
        cnt <= cnt_inc;
      end
    end
  end

endmodule
